// File: rtl/gf16_pkg.sv
// GF(2^4) arithmetic helpers shared by the masked inverter and its bench.
// Field: polynomial basis, reduction x^4 = x + 1.
package gf16_pkg;

  localparam int unsigned GF16_W = 4;
  localparam logic [GF16_W-1:0] GF16_POLY = 4'h3;

  typedef logic [GF16_W-1:0] gf16_t;

  // Squaring is linear in GF(2^4): a3 x^6 + a2 x^4 + a1 x^2 + a0 reduced.
  function automatic gf16_t gf16_sq(input gf16_t a);
    return {a[3], a[3] ^ a[1], a[2], a[2] ^ a[0]};
  endfunction

  // Fourth power, two linear squarings.
  function automatic gf16_t gf16_pow4(input gf16_t a);
    return gf16_sq(gf16_sq(a));
  endfunction

  // Plain shift-and-add product on unshared values; reference use only.
  function automatic gf16_t gf16_mul_unmasked(input gf16_t a, input gf16_t b);
    gf16_t acc;
    gf16_t t;
    acc = '0;
    t   = a;
    for (int i = 0; i < int'(GF16_W); i++) begin
      if (b[i]) acc = acc ^ t;
      t = t[3] ? (GF16_W'({t[2:0], 1'b0}) ^ GF16_POLY) : GF16_W'({t[2:0], 1'b0});
    end
    return acc;
  endfunction

endpackage

// File: rtl/gf16_inv_pipe_if.sv
// Operand/result handshake bundle for gf16_inv_pipe (two-share operand in, two-share inverse out).
interface gf16_inv_pipe_if;
  import gf16_pkg::*;

  logic  in_valid;
  logic  in_ready;
  gf16_t d0;
  gf16_t d1;
  gf16_t r_s1;
  gf16_t r_s2;
  logic  out_valid;
  logic  out_ready;
  gf16_t q0;
  gf16_t q1;

  modport master (
    output in_valid, d0, d1, r_s1, r_s2, out_ready,
    input  in_ready, out_valid, q0, q1
  );

  modport slave (
    input  in_valid, d0, d1, r_s1, r_s2, out_ready,
    output in_ready, out_valid, q0, q1
  );

endinterface

// File: rtl/gf16_dom_mul.sv
// Two-share domain-oriented GF(2^4) multiplier: four registered partial
// products (cross terms refreshed by r), compressed per output domain.
module gf16_dom_mul
  import gf16_pkg::*;
(
  input  logic  CLK,
  input  logic  RST,
  input  logic  en,
  input  gf16_t a0,
  input  gf16_t a1,
  input  gf16_t b0,
  input  gf16_t b1,
  input  gf16_t r,
  output gf16_t c0_c,
  output gf16_t c1_c
);

  gf16_t t00;
  gf16_t t01;
  gf16_t t10;
  gf16_t t11;

  // Field product used for each partial term.
  function automatic gf16_t dom_prod(input gf16_t a, input gf16_t b);
    gf16_t acc;
    gf16_t t;
    acc = '0;
    t   = a;
    for (int i = 0; i < int'(GF16_W); i++) begin
      if (b[i]) acc = acc ^ t;
      t = t[3] ? (GF16_W'({t[2:0], 1'b0}) ^ GF16_POLY) : GF16_W'({t[2:0], 1'b0});
    end
    return acc;
  endfunction

  // Capture the four partial products; cross terms carry the refresh mask.
  always_ff @(posedge CLK) begin
    if (RST) begin
      t00 <= '0;
      t01 <= '0;
      t10 <= '0;
      t11 <= '0;
    end else if (en) begin
      t00 <= dom_prod(a0, b0);
      t01 <= dom_prod(a0, b1) ^ r;
      t10 <= dom_prod(a1, b0) ^ r;
      t11 <= dom_prod(a1, b1);
    end
  end

  // Compression only mixes registered terms of the same domain.
  assign c0_c = t00 ^ t01;
  assign c1_c = t11 ^ t10;

endmodule

// File: rtl/gf16_inv_pipe.sv
// Masked GF(2^4) inverter, x^-1 = x^14, two pipeline stages with backpressure.
// Optional build macro GF16_INV_OUT_CLEAR_EN: force q0/q1 to zero while out_valid is low.
module gf16_inv_pipe
  import gf16_pkg::*;
(
  input  logic            CLK,
  input  logic            RST,
  gf16_inv_pipe_if.slave  bus
);

  logic  v1;
  logic  v2;
  logic  adv1_c;
  logic  adv2_c;
  logic  ld1_c;
  logic  ld2_c;
  gf16_t s0_c;
  gf16_t s1_c;
  gf16_t s0_q;
  gf16_t s1_q;
  gf16_t x3_0_c;
  gf16_t x3_1_c;
  gf16_t x12_0_c;
  gf16_t x12_1_c;
  gf16_t y0_c;
  gf16_t y1_c;

  // Stage advance and load conditions; data only moves with a valid operand.
  assign adv2_c = !v2 || bus.out_ready;
  assign adv1_c = !v1 || adv2_c;
  assign ld1_c  = adv1_c && bus.in_valid;
  assign ld2_c  = adv2_c && v1;

  // Per-share squares of the operand.
  assign s0_c = gf16_sq(bus.d0);
  assign s1_c = gf16_sq(bus.d1);

  // Stage 1: x^3 = x^2 * x.
  gf16_dom_mul u_mul1 (
    .CLK  (CLK),
    .RST  (RST),
    .en   (ld1_c),
    .a0   (s0_c),
    .a1   (s1_c),
    .b0   (bus.d0),
    .b1   (bus.d1),
    .r    (bus.r_s1),
    .c0_c (x3_0_c),
    .c1_c (x3_1_c)
  );

  // Delay the squares so they meet x^12 in stage 2.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s0_q <= '0;
      s1_q <= '0;
    end else if (ld1_c) begin
      s0_q <= s0_c;
      s1_q <= s1_c;
    end
  end

  // Per-share x^12 = (x^3)^4.
  assign x12_0_c = gf16_pow4(x3_0_c);
  assign x12_1_c = gf16_pow4(x3_1_c);

  // Stage 2: x^14 = x^12 * x^2.
  gf16_dom_mul u_mul2 (
    .CLK  (CLK),
    .RST  (RST),
    .en   (ld2_c),
    .a0   (x12_0_c),
    .a1   (x12_1_c),
    .b0   (s0_q),
    .b1   (s1_q),
    .r    (bus.r_s2),
    .c0_c (y0_c),
    .c1_c (y1_c)
  );

  // Valid bits follow their stage advance; bubbles propagate as zeros.
  always_ff @(posedge CLK) begin
    if (RST) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      if (adv2_c) v2 <= v1;
      if (adv1_c) v1 <= bus.in_valid;
    end
  end

  assign bus.in_ready  = adv1_c;
  assign bus.out_valid = v2;

`ifdef GF16_INV_OUT_CLEAR_EN
  assign bus.q0 = v2 ? y0_c : '0;
  assign bus.q1 = v2 ? y1_c : '0;
`else
  assign bus.q0 = y0_c;
  assign bus.q1 = y1_c;
`endif

endmodule
